mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-ported main-memory line interface between three requesters: I-cache line refill, D-cache line refill, and D-cache dirty-line write-back.
- Serialises one transaction at a time and times each transaction with an internal latency counter.
- Returns a 128-bit line plus a one-cycle completion pulse to the winning requester.
- Sits between fetch_stage/mem_stage cache request ports and the RAM array.

Parameters:
- ADDR_W, 26, line address width (byte address bits above the 16-byte offset).
- LINE_W, 128, cache line width in bits.
- LATENCY, 4, memory access cycles per transaction; legal range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- reqI_cache  in  1  I-cache refill request, level, held until ack.
- reqAddrI_mem  in  ADDR_W  I-cache refill line address.
- reqD_cache  in  1  D-cache refill request, level, held until ack.
- reqAddrD_mem  in  ADDR_W  D-cache refill line address.
- reqD_cache_write  in  1  D-cache write-back request, level, held until ack.
- reqAddrD_write_mem  in  ADDR_W  write-back line address.
- data_from_cache  in  LINE_W  write-back line data.
- data_to_cache  out  LINE_W  returned read line, shared by both caches.
- read_ready_for_icache  out  1  one-cycle pulse: I refill complete, data_to_cache valid.
- read_ready_for_dcache  out  1  one-cycle pulse: D refill complete, data_to_cache valid.
- written_data_ack  out  1  one-cycle pulse: write-back complete.
- mem_en  out  1  RAM access active.
- mem_we  out  1  RAM write strobe.
- mem_addr  out  ADDR_W  RAM line address.
- mem_wdata  out  LINE_W  RAM write data.
- mem_rdata  in  LINE_W  RAM read data, combinational from mem_addr.

Behaviour:
- Reset: synchronous, active-high; state is IDLE.
- Reset values: all outputs 0, including data_to_cache; last_grant_i=0.
- States: IDLE, BUSY_W, BUSY_D, BUSY_I, DONE.
- IDLE grant order: reqD_cache_write first, then the D/I pair.
  - Write-back always precedes a D refill, so an eviction is written before its replacement line is read.
  - Between D refill and I refill, round-robin using last_grant_i: if both are pending and last_grant_i=0, I wins; otherwise D wins.
  - A lone pending request always wins.
- On grant:
  - Latch address, plus write data for a write-back.
  - Load cnt <= LATENCY-1.
  - Set last_grant_i = (grant is I). A write-back grant sets last_grant_i=0.
- BUSY_x:
  - mem_en=1 and mem_addr=latched address.
  - mem_we=1 only in BUSY_W; mem_wdata=latched data.
  - cnt decrements each cycle.
  - At cnt==0: read states capture mem_rdata into data_to_cache; go to DONE.
- DONE:
  - Exactly one of read_ready_for_icache, read_ready_for_dcache or written_data_ack is 1 for this single cycle.
  - mem_en=0.
  - Next state IDLE.
- Latency: a request seen in IDLE at cycle 0 gives mem_en on cycles 1..LATENCY and the ack pulse on cycle LATENCY+1. Next grant is no earlier than cycle LATENCY+2.
- Requesters drop their request in the cycle after the ack. IDLE after DONE therefore never regrants the same request.
- data_to_cache holds its value until the next read completes. Write-backs do not change it.
- Inputs are ignored while BUSY/DONE. A request dropped mid-transaction still completes and acks.
- Reset mid-transaction: next cycle is IDLE with mem_en=0 and no ack pulse. The aborted transaction is not replayed unless its request is still asserted.
- Acks are always mutually exclusive, and mem_en=0 in IDLE and DONE.

Test Plan:
1. LATENCY=4, reqI_cache=1 with addr 0x0000010 at cycle 0 in IDLE, mem_rdata=0xA5..A5 -> mem_en high on cycles 1-4 with mem_addr=0x10 and mem_we=0; read_ready_for_icache pulse on cycle 5; data_to_cache=0xA5..A5.
2. Write-back (addr 0x20, data 0x11..11), D refill (addr 0x20) and I refill (addr 0x40) all raised together -> grants in order W, I, D; written_data_ack on cycle 5, I ack on cycle 11, D ack on cycle 17; D refill reads addr 0x20 after the write.
3. Continuous back-to-back reqD_cache with reqI_cache held -> I and D grants alternate; I is granted within one D transaction.
4. reset asserted on cycle 2 of a BUSY_D transaction -> next cycle IDLE, mem_en=0, no read_ready_for_dcache pulse; all outputs 0.
5. LATENCY=1, I read -> single mem_en cycle (cycle 1), ack on cycle 2; a new request is granted on cycle 3.
6. I read returns 0xBEEF.., then a write-back completes -> data_to_cache stays 0xBEEF..; mem_we is never high in read transactions.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory line port between D write-back, D refill and I refill.
// One transaction at a time: LATENCY busy cycles, then a one-cycle ack pulse.
module mem_port_arbiter #(
  parameter int ADDR_W  = 26,
  parameter int LINE_W  = 128,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqI_cache,
  input  logic [ADDR_W-1:0] reqAddrI_mem,
  input  logic              reqD_cache,
  input  logic [ADDR_W-1:0] reqAddrD_mem,
  input  logic              reqD_cache_write,
  input  logic [ADDR_W-1:0] reqAddrD_write_mem,
  input  logic [LINE_W-1:0] data_from_cache,
  output logic [LINE_W-1:0] data_to_cache,
  output logic              read_ready_for_icache,
  output logic              read_ready_for_dcache,
  output logic              written_data_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] BUSY_W = 3'd1;
  localparam logic [2:0] BUSY_D = 3'd2;
  localparam logic [2:0] BUSY_I = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              last_grant_i_q, last_grant_i_d;
  logic [2:0]        ack_q, ack_d;  // {write-back, D refill, I refill}
  logic              grant_w, grant_i, grant_d;
  logic              busy;

  // Write-back first so an evicted line lands before its replacement is read.
  always_comb begin
    grant_w = reqD_cache_write;
    grant_i = !reqD_cache_write && reqI_cache && (!reqD_cache || !last_grant_i_q);
    grant_d = !reqD_cache_write && reqD_cache && !grant_i;
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    last_grant_i_d = last_grant_i_q;
    ack_d          = 3'b000;
    case (state_q)
      IDLE: begin
        cnt_d = CNT_INIT;
        if (grant_w) begin
          state_d        = BUSY_W;
          addr_d         = reqAddrD_write_mem;
          wdata_d        = data_from_cache;
          last_grant_i_d = 1'b0;
        end else if (grant_i) begin
          state_d        = BUSY_I;
          addr_d         = reqAddrI_mem;
          last_grant_i_d = 1'b1;
        end else if (grant_d) begin
          state_d        = BUSY_D;
          addr_d         = reqAddrD_mem;
          last_grant_i_d = 1'b0;
        end
      end
      BUSY_W, BUSY_D, BUSY_I: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          cnt_d   = 4'd0;
          case (state_q)
            BUSY_W: ack_d = 3'b100;
            BUSY_D: begin
              ack_d   = 3'b010;
              rdata_d = mem_rdata;
            end
            default: begin
              ack_d   = 3'b001;
              rdata_d = mem_rdata;
            end
          endcase
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      last_grant_i_q <= 1'b0;
      ack_q          <= 3'b000;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rdata_q        <= rdata_d;
      last_grant_i_q <= last_grant_i_d;
      ack_q          <= ack_d;
    end
  end

  // Address and write data are forced to zero outside an active access.
  assign busy                  = (state_q == BUSY_W) || (state_q == BUSY_D) || (state_q == BUSY_I);
  assign mem_en                = busy;
  assign mem_we                = (state_q == BUSY_W);
  assign mem_addr              = busy ? addr_q : '0;
  assign mem_wdata             = mem_we ? wdata_q : '0;
  assign data_to_cache         = rdata_q;
  assign read_ready_for_icache = ack_q[0];
  assign read_ready_for_dcache = ack_q[1];
  assign written_data_ack      = ack_q[2];

endmodule
